read_serializer: RTL



---
 rtl/read_serializer_pkg.sv | 20 ++
 rtl/read_serializer_if.sv | 26 ++
 rtl/read_ser_shifter.sv | 44 ++++
 rtl/read_serializer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/read_serializer_pkg.sv
// Shared types and helpers for the burst read serializer.
// Optional feature macro: READ_SERIALIZER_PARITY_EN (per-word even parity bit).
package read_serializer_pkg;

  localparam int STATE_W    = 2;
  localparam int PAR_DATA_W = 64;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Words up to PAR_DATA_W bits are zero-extended by the caller.
  function automatic logic parity_even(input logic [PAR_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/read_serializer_if.sv
// Buffer-read and serial-out bundle of the read serializer.
// slave = serializer side, master = buffer / SPI front end side.
interface read_serializer_if #(
  parameter int WL = 8,
  parameter int AW = 5
);
  logic          iSTART;
  logic          iEN;
  logic [WL-1:0] iDATA;
  logic          oMISO;
  logic          oMISO_OE;
  logic          oRd_EN;
  logic [AW-1:0] oRd_ADDR;
  logic          oBUSY;
  logic          oRd_DONE;

  modport slave (
    input  iSTART, iEN, iDATA,
    output oMISO, oMISO_OE, oRd_EN, oRd_ADDR, oBUSY, oRd_DONE
  );

  modport master (
    output iSTART, iEN, iDATA,
    input  oMISO, oMISO_OE, oRd_EN, oRd_ADDR, oBUSY, oRd_DONE
  );
endinterface

// File: rtl/read_ser_shifter.sv
// WL-bit loadable shift register with bit-order select.
// With READ_SERIALIZER_PARITY_EN the even parity of each loaded word is held.
module read_ser_shifter
  import read_serializer_pkg::*;
#(
  parameter int WL        = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [WL-1:0] i_data,
  input  logic          i_shift,
  output logic          o_bit,
  output logic          o_parity
);

  logic [WL-1:0] r_sreg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_sreg <= '0;
    else if (i_clr)   r_sreg <= '0;
    else if (i_load)  r_sreg <= i_data;
    else if (i_shift) r_sreg <= MSB_FIRST ? {r_sreg[WL-2:0], 1'b0} : {1'b0, r_sreg[WL-1:1]};
  end

  assign o_bit = MSB_FIRST ? r_sreg[WL-1] : r_sreg[0];

`ifdef READ_SERIALIZER_PARITY_EN
  logic r_par;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_par <= 1'b0;
    else if (i_clr)  r_par <= 1'b0;
    else if (i_load) r_par <= parity_even(PAR_DATA_W'(i_data));
  end

  assign o_parity = r_par;
`else
  assign o_parity = 1'b0;
`endif

endmodule

// File: rtl/read_serializer.sv
// Burst read serializer: fetches [START_ADDR..END_ADDR] from a synchronous buffer
// and shifts each word out per iEN strobe; macro READ_SERIALIZER_PARITY_EN adds a parity slot.
module read_serializer
  import read_serializer_pkg::*;
#(
  parameter int WL         = 8,
  parameter int AW         = 5,
  parameter int START_ADDR = 20,
  parameter int END_ADDR   = 28,
  parameter int MSB_FIRST  = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCLR,
  read_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WL + 1);
`ifdef READ_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_RELOAD  = PAR_EN ? CNT_W'(WL) : CNT_W'(WL - 1);
  localparam logic [AW-1:0]    ADDR_FIRST  = AW'(START_ADDR);
  localparam logic [AW-1:0]    ADDR_SECOND = AW'(START_ADDR + 1);
  localparam logic [AW-1:0]    WORDS_EXTRA = AW'(END_ADDR - START_ADDR);

  if (WL < 2 || WL > PAR_DATA_W || START_ADDR < 0 || START_ADDR > END_ADDR ||
      END_ADDR > (2**AW) - 1) begin : g_param_check
    $error("read_serializer: illegal WL or burst address range");
  end

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_words_left;
  logic [CNT_W-1:0] r_cnt;
  logic [WL-1:0]   r_pf_data;
  logic            r_pf_req;
  logic            r_pf_pend;
  logic            r_busy;
  logic            r_oe;
  logic            r_done;

  logic            w_start;
  logic            w_pf_rd;
  logic            w_bound;
  logic            w_shift;
  logic            w_load;
  logic [WL-1:0]   w_load_data;
  logic            w_bit;
  logic            w_parity;
  logic            w_par_slot;

  assign w_start = (r_state == S_IDLE) && bus.iSTART && !iCLR && !iRST;
  assign w_pf_rd = (r_state == S_SHIFT) && r_pf_req && (r_words_left != '0) && !iCLR;
  assign w_bound = (r_state == S_SHIFT) && bus.iEN && (r_cnt == '0);
  assign w_shift = (r_state == S_SHIFT) && bus.iEN && (r_cnt != '0);
  assign w_load  = !iCLR && ((r_state == S_FETCH) || (w_bound && (r_words_left != '0)));
  // Bypass covers a boundary landing on the same edge the prefetch is captured.
  assign w_load_data = ((r_state == S_FETCH) || r_pf_pend) ? bus.iDATA : r_pf_data;

  read_ser_shifter #(
    .WL        (WL),
    .MSB_FIRST (MSB_FIRST != 0)
  ) u_shifter (
    .i_clk    (iCLK),
    .i_rst    (iRST),
    .i_clr    (iCLR),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_shift  (w_shift),
    .o_bit    (w_bit),
    .o_parity (w_parity)
  );

  assign w_par_slot   = PAR_EN && (r_cnt == '0);
  assign bus.oMISO    = r_oe && (w_par_slot ? w_parity : w_bit);
  assign bus.oMISO_OE = r_oe;
  assign bus.oRd_EN   = w_start || w_pf_rd;
  assign bus.oRd_ADDR = r_addr;
  assign bus.oBUSY    = r_busy;
  assign bus.oRd_DONE = r_done;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_addr       <= ADDR_FIRST;
      r_words_left <= '0;
      r_cnt        <= '0;
      r_pf_data    <= '0;
      r_pf_req     <= 1'b0;
      r_pf_pend    <= 1'b0;
      r_busy       <= 1'b0;
      r_oe         <= 1'b0;
      r_done       <= 1'b0;
    end else if (iCLR) begin
      r_state      <= S_IDLE;
      r_addr       <= ADDR_FIRST;
      r_words_left <= '0;
      r_cnt        <= '0;
      r_pf_data    <= '0;
      r_pf_req     <= 1'b0;
      r_pf_pend    <= 1'b0;
      r_busy       <= 1'b0;
      r_oe         <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_cnt        <= CNT_RELOAD;
          r_addr       <= ADDR_SECOND;
          r_words_left <= WORDS_EXTRA;
          r_pf_req     <= 1'b1;
          r_oe         <= 1'b1;
          r_state      <= S_SHIFT;
        end
        S_SHIFT: begin
          r_pf_req  <= 1'b0;
          r_pf_pend <= w_pf_rd;
          if (w_pf_rd)   r_addr    <= r_addr + 1'b1;
          if (r_pf_pend) r_pf_data <= bus.iDATA;
          if (w_shift) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_bound) begin
            if (r_words_left != '0) begin
              r_cnt        <= CNT_RELOAD;
              r_words_left <= r_words_left - 1'b1;
              r_pf_req     <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_oe    <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_addr  <= ADDR_FIRST;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
